// File: rtl/skip_decode.sv
// Skip-pattern decoder: learns a periodic pulse-skip pattern of LEN positions, verifies it, then tracks it.
// Optional statistics outputs (oSKIPS, oERRCNT) are built only when SKIP_DECODE_STATS_EN is defined.
module skip_decode #(
    parameter int LEN    = 16,
    parameter int ERRMAX = 3
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iE,
    input  logic                     iP,
    output logic [LEN-1:0]           oMASK,
    output logic [$clog2(LEN)-1:0]   oPOS,
    output logic                     oLOCK,
    output logic                     oERR,
    output logic [$clog2(LEN):0]     oSKIPS,
    output logic [15:0]              oERRCNT
);

    localparam int PW = $clog2(LEN);
    localparam int MW = $clog2(ERRMAX + 1);
    localparam logic [PW-1:0] POS_LAST   = PW'(LEN - 1);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [MW-1:0] MISS_ONE   = MW'(1);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(ERRMAX);
    localparam logic [LEN-1:0] MASK_FIRST = {{(LEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LEARN  = 2'd1,
        VERIFY = 2'd2,
        LOCK   = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   pos_r, pos_s;
    logic [LEN-1:0]  mask_r, mask_s;
    logic            lock_r;
    logic            err_r, err_s;
    logic [MW-1:0]   miss_cnt_r, miss_cnt_s;
    logic            miss_seen_r, miss_seen_s;
    logic            mismatch_s;
    logic            last_s;

    // Next-state, pattern and mismatch-tracking logic
    always_comb begin
        state_s     = state_r;
        pos_s       = pos_r;
        mask_s      = mask_r;
        err_s       = 1'b0;
        miss_cnt_s  = miss_cnt_r;
        miss_seen_s = miss_seen_r;
        mismatch_s  = ((~iP) != mask_r[pos_r]);
        last_s      = (pos_r == POS_LAST);

        if (iE) begin
            case (state_r)
                HUNT: begin
                    if (!iP) begin
                        mask_s  = MASK_FIRST;
                        pos_s   = POS_ONE;
                        state_s = LEARN;
                    end else begin
                        pos_s = '0;
                    end
                end
                LEARN: begin
                    mask_s[pos_r] = ~iP;
                    pos_s         = pos_r + POS_ONE;
                    if (last_s) begin
                        state_s = VERIFY;
                    end else begin
                        state_s = LEARN;
                    end
                end
                VERIFY: begin
                    if (mismatch_s) begin
                        mask_s  = '0;
                        pos_s   = '0;
                        state_s = HUNT;
                    end else if (last_s) begin
                        pos_s       = '0;
                        miss_cnt_s  = '0;
                        miss_seen_s = 1'b0;
                        state_s     = LOCK;
                    end else begin
                        pos_s = pos_r + POS_ONE;
                    end
                end
                LOCK: begin
                    pos_s = pos_r + POS_ONE;
                    if (mismatch_s) begin
                        err_s = 1'b1;
                        if ((miss_cnt_r + MISS_ONE) == MISS_LIMIT) begin
                            // Too many errors without a clean period: drop lock and relearn
                            state_s     = HUNT;
                            mask_s      = '0;
                            pos_s       = '0;
                            miss_cnt_s  = '0;
                            miss_seen_s = 1'b0;
                        end else begin
                            miss_cnt_s  = miss_cnt_r + MISS_ONE;
                            miss_seen_s = !last_s;
                        end
                    end else if (last_s) begin
                        if (!miss_seen_r) begin
                            miss_cnt_s = '0;
                        end else begin
                            miss_cnt_s = miss_cnt_r;
                        end
                        miss_seen_s = 1'b0;
                    end else begin
                        miss_cnt_s = miss_cnt_r;
                    end
                end
                default: begin
                    state_s     = HUNT;
                    mask_s      = '0;
                    pos_s       = '0;
                    miss_cnt_s  = '0;
                    miss_seen_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Core state registers; lock and error flags are registered from the next state
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r     <= HUNT;
            pos_r       <= '0;
            mask_r      <= '0;
            lock_r      <= 1'b0;
            err_r       <= 1'b0;
            miss_cnt_r  <= '0;
            miss_seen_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pos_r       <= pos_s;
            mask_r      <= mask_s;
            lock_r      <= (state_s == LOCK);
            err_r       <= err_s;
            miss_cnt_r  <= miss_cnt_s;
            miss_seen_r <= miss_seen_s;
        end
    end

    assign oMASK = mask_r;
    assign oPOS  = pos_r;
    assign oLOCK = lock_r;
    assign oERR  = err_r;

`ifdef SKIP_DECODE_STATS_EN
    function automatic logic [PW:0] popcount(input logic [LEN-1:0] v);
        logic [PW:0] c;
        c = '0;
        for (int i = 0; i < LEN; i++) begin
            c = c + {{PW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [PW:0] skips_r;
    logic [15:0] errcnt_r;

    // Skip count is captured once at lock; error count saturates and clears only on reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            skips_r  <= '0;
            errcnt_r <= 16'h0000;
        end else begin
            if ((state_r == VERIFY) && (state_s == LOCK)) begin
                skips_r <= popcount(mask_r);
            end else begin
                skips_r <= skips_r;
            end
            if (err_s && (errcnt_r != 16'hFFFF)) begin
                errcnt_r <= errcnt_r + 16'd1;
            end else begin
                errcnt_r <= errcnt_r;
            end
        end
    end

    assign oSKIPS  = skips_r;
    assign oERRCNT = errcnt_r;
`else
    assign oSKIPS  = '0;
    assign oERRCNT = 16'h0000;
`endif

endmodule

// File: tb/tb_skip_decode.sv
// Directed self-checking bench for skip_decode (LEN=16, ERRMAX=3), with or without SKIP_DECODE_STATS_EN.
module tb_skip_decode;

    logic        iCLK;
    logic        iRST;
    logic        iE;
    logic        iP;
    logic [15:0] oMASK;
    logic [3:0]  oPOS;
    logic        oLOCK;
    logic        oERR;
    logic [4:0]  oSKIPS;
    logic [15:0] oERRCNT;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SKIP_DECODE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    skip_decode #(.LEN(16), .ERRMAX(3)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iE      (iE),
        .iP      (iP),
        .oMASK   (oMASK),
        .oPOS    (oPOS),
        .oLOCK   (oLOCK),
        .oERR    (oERR),
        .oSKIPS  (oSKIPS),
        .oERRCNT (oERRCNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic e, input logic p, input logic r);
        iRST = r;
        iE   = e;
        iP   = p;
        @(posedge iCLK);
        #1;
    endtask

    // One sample of a pattern position: a 1 in the pattern means the pulse is skipped
    task automatic feed(input logic [15:0] pat, input int k);
        logic [15:0] pv;
        pv = pat;
        tick(1'b1, ~pv[k], 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mask"},   32'(oMASK),   32'h0);
        chk({tag, "_pos"},    32'(oPOS),    32'h0);
        chk({tag, "_lock"},   32'(oLOCK),   32'h0);
        chk({tag, "_err"},    32'(oERR),    32'h0);
        chk({tag, "_skips"},  32'(oSKIPS),  32'h0);
        chk({tag, "_errcnt"}, 32'(oERRCNT), 32'h0);
    endtask

    initial begin
        logic [15:0] pa;
        logic [15:0] pb;
        pa   = 16'h0101;
        pb   = 16'h0011;
        iRST = 1'b1;
        iE   = 1'b0;
        iP   = 1'b1;

        // Reset state
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        chk_zero("reset");

        // All-pass stream stays in HUNT
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            chk("allpass_lock", 32'(oLOCK), 32'h0);
            chk("allpass_pos",  32'(oPOS),  32'h0);
        end
        chk("allpass_mask", 32'(oMASK), 32'h0);

        // Learn and lock on 0x0101
        feed(pa, 0);
        chk("learn0_pos",  32'(oPOS),  32'h1);
        chk("learn0_mask", 32'(oMASK), 32'h1);
        for (int k = 1; k < 16; k++) feed(pa, k);
        chk("learned_mask", 32'(oMASK), 32'h0101);
        chk("learned_pos",  32'(oPOS),  32'h0);
        chk("learned_lock", 32'(oLOCK), 32'h0);
        for (int k = 0; k < 15; k++) feed(pa, k);
        chk("prelock", 32'(oLOCK), 32'h0);
        feed(pa, 15);
        chk("lock_a",       32'(oLOCK),  32'h1);
        chk("lock_a_mask",  32'(oMASK),  32'h0101);
        chk("lock_a_pos",   32'(oPOS),   32'h0);
        chk("lock_a_skips", 32'(oSKIPS), STATS ? 32'h2 : 32'h0);

        // Enable low in LOCK holds position
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("hold_pos",  32'(oPOS),  32'h0);
            chk("hold_lock", 32'(oLOCK), 32'h1);
        end

        // Single extra skip at position 5
        for (int k = 0; k < 5; k++) feed(pa, k);
        tick(1'b1, 1'b0, 1'b0);
        chk("err1_err",    32'(oERR),    32'h1);
        chk("err1_lock",   32'(oLOCK),   32'h1);
        chk("err1_pos",    32'(oPOS),    32'h6);
        chk("err1_errcnt", 32'(oERRCNT), STATS ? 32'h1 : 32'h0);
        feed(pa, 6);
        chk("err1_pulse_end", 32'(oERR), 32'h0);
        for (int k = 7; k < 16; k++) feed(pa, k);
        for (int k = 0; k < 16; k++) feed(pa, k);
        chk("clean_lock", 32'(oLOCK), 32'h1);
        chk("clean_pos",  32'(oPOS),  32'h0);

        // Three mismatches in one period lose lock on the third
        feed(pa, 0);
        feed(pa, 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("m1_err",  32'(oERR),  32'h1);
        chk("m1_lock", 32'(oLOCK), 32'h1);
        tick(1'b1, 1'b0, 1'b0);
        chk("m2_err",  32'(oERR),  32'h1);
        chk("m2_lock", 32'(oLOCK), 32'h1);
        tick(1'b1, 1'b0, 1'b0);
        chk("m3_lock",   32'(oLOCK),   32'h0);
        chk("m3_err",    32'(oERR),    32'h1);
        chk("m3_mask",   32'(oMASK),   32'h0);
        chk("m3_pos",    32'(oPOS),    32'h0);
        chk("m3_errcnt", 32'(oERRCNT), STATS ? 32'h4 : 32'h0);
        tick(1'b1, 1'b1, 1'b0);
        chk("m3_hunt_pos",  32'(oPOS),  32'h0);
        chk("m3_hunt_lock", 32'(oLOCK), 32'h0);

        // Learn 0x0011 with a 7-cycle enable gap mid-pattern
        feed(pb, 0);
        chk("b_learn_pos", 32'(oPOS), 32'h1);
        for (int k = 1; k < 4; k++) feed(pb, k);
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, i[0], 1'b0);
            chk("gap_pos",  32'(oPOS),  32'h4);
            chk("gap_mask", 32'(oMASK), 32'h1);
        end
        for (int k = 4; k < 16; k++) feed(pb, k);
        chk("b_learned_mask", 32'(oMASK), 32'h0011);
        chk("b_learned_lock", 32'(oLOCK), 32'h0);
        for (int k = 0; k < 15; k++) feed(pb, k);
        chk("b_prelock", 32'(oLOCK), 32'h0);
        feed(pb, 15);
        chk("b_lock",       32'(oLOCK),  32'h1);
        chk("b_lock_mask",  32'(oMASK),  32'h0011);
        chk("b_lock_skips", 32'(oSKIPS), STATS ? 32'h2 : 32'h0);

        // Reset from LOCK with enable high and a skip present
        tick(1'b1, 1'b0, 1'b1);
        chk_zero("rst_lock");

        // Reset during VERIFY
        for (int k = 0; k < 16; k++) feed(pb, k);
        for (int k = 0; k < 5; k++) feed(pb, k);
        chk("verify_pos",  32'(oPOS),  32'h5);
        chk("verify_lock", 32'(oLOCK), 32'h0);
        chk("verify_mask", 32'(oMASK), 32'h0011);
        tick(1'b1, 1'b1, 1'b1);
        chk_zero("rst_verify");
        tick(1'b1, 1'b1, 1'b0);
        chk("post_rst_pos",  32'(oPOS),  32'h0);
        chk("post_rst_mask", 32'(oMASK), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
